multi_timer: RTL and testbench

//  Parametrised successor to the single-compare timer peripheral: one shared 64-bit mtime counter,
//  a programmable prescaler and NumChannels independent 64-bit compare channels, each one-shot or

---
 rtl/multi_timer.sv | 223 ++++++++++++++++++++++
 tb/tb_multi_timer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/multi_timer.sv
// multi_timer: shared 64-bit mtime with a programmable prescaler and NumChannels
// one-shot/periodic compare channels, exposed as a fixed-latency bus device.
module multi_timer #(
  parameter int unsigned NumChannels    = 4,
  parameter int unsigned PrescalerWidth = 16,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned AddressWidth   = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    device_req_i,
  input  logic [AddressWidth-1:0] device_addr_i,
  input  logic                    device_we_i,
  input  logic [3:0]              device_be_i,
  input  logic [DataWidth-1:0]    device_wdata_i,
  output logic                    device_rvalid_o,
  output logic [DataWidth-1:0]    device_rdata_o,
  output logic                    device_err_o,
  output logic [NumChannels-1:0]  irq_vec_o,
  output logic                    timer_irq_o
);

  localparam logic [2:0] RegCtrl     = 3'd0;
  localparam logic [2:0] RegPrescale = 3'd1;
  localparam logic [2:0] RegMtimeLo  = 3'd2;
  localparam logic [2:0] RegMtimeHi  = 3'd3;
  localparam logic [2:0] RegStatus   = 3'd4;
  localparam logic [2:0] RegIrqEn    = 3'd5;

  function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                           input logic [31:0] new_val,
                                           input logic [3:0]  be);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = be[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
    end
    return res;
  endfunction

  // Address decode: global block at 0x000..0x014, channels at 0x100 + 0x10*c.
  logic [11:0] offset;
  logic [3:0]  ch_idx;
  logic [1:0]  ch_reg;
  logic [2:0]  glb_reg;
  logic [31:0] wdata;
  logic        glb_sel, ch_sel, addr_ok, wr_en, rd_en;
  logic        wr_ctrl, wr_prescale, wr_mtime_lo, wr_mtime_hi, wr_status, wr_irq_en;
  logic        unused_addr;

  assign offset      = device_addr_i[11:0];
  assign unused_addr = ^{device_addr_i[AddressWidth-1:12], device_addr_i[1:0]};
  assign wdata       = device_wdata_i;
  assign glb_reg     = offset[4:2];
  assign ch_idx      = offset[7:4];
  assign ch_reg      = offset[3:2];
  assign glb_sel     = (offset[11:5] == 7'd0) && (glb_reg <= RegIrqEn);
  assign ch_sel      = (offset[11:8] == 4'h1) && ({1'b0, ch_idx} < 5'(NumChannels));
  assign addr_ok     = glb_sel || ch_sel;
  assign wr_en       = device_req_i && device_we_i && addr_ok;
  assign rd_en       = device_req_i && !device_we_i && addr_ok;

  assign wr_ctrl     = wr_en && glb_sel && (glb_reg == RegCtrl);
  assign wr_prescale = wr_en && glb_sel && (glb_reg == RegPrescale);
  assign wr_mtime_lo = wr_en && glb_sel && (glb_reg == RegMtimeLo);
  assign wr_mtime_hi = wr_en && glb_sel && (glb_reg == RegMtimeHi);
  assign wr_status   = wr_en && glb_sel && (glb_reg == RegStatus);
  assign wr_irq_en   = wr_en && glb_sel && (glb_reg == RegIrqEn);

  logic                      enable_reg;
  logic [PrescalerWidth-1:0] prescale_reg, prescale_next, pcnt_reg, pcnt_next;
  logic [63:0]               mtime_reg, mtime_next;
  logic [NumChannels-1:0]    status_reg, status_next, irq_en_reg, irq_en_next;
  logic [31:0]               shadow_reg, shadow_next, rd_data;
  logic                      rvalid_reg, err_reg;
  logic [31:0]               rdata_reg;
  logic                      tick;

  logic [63:0]            cmp_arr    [NumChannels];
  logic [31:0]            period_arr [NumChannels];
  logic [NumChannels-1:0] ch_en_vec, periodic_vec, match_vec;

  assign tick = enable_reg && (pcnt_reg == prescale_reg);

  always_comb begin
    prescale_next = prescale_reg;
    irq_en_next   = irq_en_reg;
    for (int i = 0; i < PrescalerWidth; i++) begin
      if (device_be_i[i/8]) prescale_next[i] = wdata[i];
    end
    for (int i = 0; i < NumChannels; i++) begin
      if (device_be_i[i/8]) irq_en_next[i] = wdata[i];
    end
  end

  always_comb begin
    pcnt_next = pcnt_reg;
    if (wr_prescale)     pcnt_next = '0;
    else if (tick)       pcnt_next = '0;
    else if (enable_reg) pcnt_next = pcnt_reg + 1'b1;
  end

  // A software write to either half discards that cycle's increment.
  always_comb begin
    mtime_next = mtime_reg;
    if (tick) mtime_next = mtime_reg + 64'd1;
    if (wr_mtime_lo)      mtime_next = {mtime_reg[63:32], be_merge(mtime_reg[31:0], wdata, device_be_i)};
    else if (wr_mtime_hi) mtime_next = {be_merge(mtime_reg[63:32], wdata, device_be_i), mtime_reg[31:0]};
  end

  // Match sets are OR-ed in after the W1C so a same-cycle match survives the clear.
  always_comb begin
    status_next = status_reg;
    for (int i = 0; i < NumChannels; i++) begin
      if (wr_status && device_be_i[i/8] && wdata[i]) status_next[i] = 1'b0;
    end
    status_next = status_next | match_vec;
  end

  always_comb begin
    rd_data     = '0;
    shadow_next = shadow_reg;
    if (glb_sel) begin
      case (glb_reg)
        RegCtrl:     rd_data = {31'd0, enable_reg};
        RegPrescale: rd_data = 32'(prescale_reg);
        RegMtimeLo:  rd_data = mtime_reg[31:0];
        RegMtimeHi:  rd_data = shadow_reg;
        RegStatus:   rd_data = 32'(status_reg);
        RegIrqEn:    rd_data = 32'(irq_en_reg);
        default:     rd_data = '0;
      endcase
      if (rd_en && glb_reg == RegMtimeLo) shadow_next = mtime_reg[63:32];
    end else if (ch_sel) begin
      for (int i = 0; i < NumChannels; i++) begin
        if (ch_idx == 4'(i)) begin
          case (ch_reg)
            2'd0:    rd_data = cmp_arr[i][31:0];
            2'd1:    rd_data = shadow_reg;
            2'd2:    rd_data = {30'd0, periodic_vec[i], ch_en_vec[i]};
            default: rd_data = period_arr[i];
          endcase
          if (rd_en && ch_reg == 2'd0) shadow_next = cmp_arr[i][63:32];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      enable_reg   <= 1'b0;
      prescale_reg <= '0;
      pcnt_reg     <= '0;
      mtime_reg    <= '0;
      status_reg   <= '0;
      irq_en_reg   <= '0;
      shadow_reg   <= '0;
      rvalid_reg   <= 1'b0;
      err_reg      <= 1'b0;
      rdata_reg    <= '0;
    end else begin
      if (wr_ctrl && device_be_i[0]) enable_reg <= wdata[0];
      if (wr_prescale) prescale_reg <= prescale_next;
      if (wr_irq_en)   irq_en_reg   <= irq_en_next;
      pcnt_reg   <= pcnt_next;
      mtime_reg  <= mtime_next;
      status_reg <= status_next;
      shadow_reg <= shadow_next;
      rvalid_reg <= device_req_i;
      err_reg    <= device_req_i && !addr_ok;
      rdata_reg  <= rd_en ? rd_data : '0;
    end
  end

  for (genvar gi = 0; gi < NumChannels; gi++) begin : g_ch
    logic        ch_wr, wr_cmp_lo, wr_cmp_hi, wr_ch_ctrl, wr_period, match;
    logic        ch_en_reg, periodic_reg;
    logic [63:0] cmp_reg;
    logic [31:0] period_reg;

    assign ch_wr      = wr_en && ch_sel && (ch_idx == 4'(gi));
    assign wr_cmp_lo  = ch_wr && (ch_reg == 2'd0);
    assign wr_cmp_hi  = ch_wr && (ch_reg == 2'd1);
    assign wr_ch_ctrl = ch_wr && (ch_reg == 2'd2);
    assign wr_period  = ch_wr && (ch_reg == 2'd3);
    assign match      = ch_en_reg && (mtime_reg >= cmp_reg);

    // Software writes take priority over auto-clear and auto-reload.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        ch_en_reg    <= 1'b0;
        periodic_reg <= 1'b0;
        cmp_reg      <= '1;
        period_reg   <= '0;
      end else begin
        if (wr_ch_ctrl) begin
          if (device_be_i[0]) begin
            ch_en_reg    <= wdata[0];
            periodic_reg <= wdata[1];
          end
        end else if (match && !periodic_reg) begin
          ch_en_reg <= 1'b0;
        end
        if (wr_cmp_lo)                  cmp_reg[31:0]  <= be_merge(cmp_reg[31:0], wdata, device_be_i);
        else if (wr_cmp_hi)             cmp_reg[63:32] <= be_merge(cmp_reg[63:32], wdata, device_be_i);
        else if (match && periodic_reg) cmp_reg        <= cmp_reg + {32'd0, period_reg};
        if (wr_period) period_reg <= be_merge(period_reg, wdata, device_be_i);
      end
    end

    assign cmp_arr[gi]      = cmp_reg;
    assign period_arr[gi]   = period_reg;
    assign ch_en_vec[gi]    = ch_en_reg;
    assign periodic_vec[gi] = periodic_reg;
    assign match_vec[gi]    = match;
  end

  assign device_rvalid_o = rvalid_reg;
  assign device_rdata_o  = rdata_reg;
  assign device_err_o    = err_reg;
  assign irq_vec_o       = status_reg & irq_en_reg;
  assign timer_irq_o     = |irq_vec_o;

endmodule

// File: tb/tb_multi_timer.sv
// Directed bench for multi_timer: register defaults, prescaler, one-shot and
// periodic channels, 64-bit wrap and shadow reads, bus errors and collisions.
module tb_multi_timer;
  localparam int NCH = 4;

  logic           clk_i = 1'b0;
  logic           rst_i = 1'b1;
  logic           req = 1'b0;
  logic           we = 1'b0;
  logic [31:0]    addr = '0;
  logic [31:0]    wdata = '0;
  logic [3:0]     be = '0;
  logic           rvalid;
  logic [31:0]    rdata;
  logic           err;
  logic [NCH-1:0] irq_vec;
  logic           timer_irq;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_i = ~clk_i;

  multi_timer #(
    .NumChannels(NCH), .PrescalerWidth(16), .DataWidth(32), .AddressWidth(32)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .device_req_i(req), .device_addr_i(addr), .device_we_i(we),
    .device_be_i(be), .device_wdata_i(wdata),
    .device_rvalid_o(rvalid), .device_rdata_o(rdata), .device_err_o(err),
    .irq_vec_o(irq_vec), .timer_irq_o(timer_irq)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic bus_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] b, output logic [31:0] rd, output logic er);
    @(negedge clk_i);
    req = 1'b1; we = w; addr = a; wdata = d; be = b;
    @(negedge clk_i);
    req = 1'b0; we = 1'b0;
    check_val($sformatf("rvalid@%03h", a[11:0]), 64'(rvalid), 64'd1);
    rd = rdata;
    er = err;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b = 4'hF);
    logic [31:0] rd;
    logic        er;
    bus_xfer(1'b1, a, d, b, rd, er);
    check_val($sformatf("werr@%03h", a[11:0]), 64'(er), 64'd0);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    logic        er;
    bus_xfer(1'b0, a, 32'd0, 4'hF, rd, er);
    check_val(tag, 64'(rd), 64'(exp));
    check_val({tag, ".err"}, 64'(er), 64'd0);
  endtask

  // Two back-to-back full-word writes, then one idle cycle so matches settle.
  task automatic wr_pair(input logic [31:0] a0, input logic [31:0] d0,
                         input logic [31:0] a1, input logic [31:0] d1);
    @(negedge clk_i);
    req = 1'b1; we = 1'b1; be = 4'hF; addr = a0; wdata = d0;
    @(negedge clk_i);
    addr = a1; wdata = d1;
    @(negedge clk_i);
    req = 1'b0; we = 1'b0;
    @(negedge clk_i);
  endtask

  // With PRESCALE=0, enabling for exactly one cycle yields exactly one tick.
  task automatic tick_once();
    wr_pair(32'h000, 32'd1, 32'h000, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [31:0] def_addr [12];
    logic [31:0] def_val  [12];
    int          cyc;
    logic        exp_irq;

    def_addr = '{32'h000, 32'h004, 32'h008, 32'h00C, 32'h010, 32'h014,
                 32'h100, 32'h104, 32'h108, 32'h10C, 32'h130, 32'h134};
    def_val  = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

    // Reset, with a request issued while reset is asserted: its response is dropped.
    repeat (2) @(negedge clk_i);
    req = 1'b1;
    @(negedge clk_i);
    req = 1'b0;
    check_val("rst.rvalid", 64'(rvalid), 64'd0);
    check_val("rst.rdata", 64'(rdata), 64'd0);
    check_val("rst.err", 64'(err), 64'd0);
    check_val("rst.irq_vec", 64'(irq_vec), 64'd0);
    check_val("rst.timer_irq", 64'(timer_irq), 64'd0);
    @(negedge clk_i);
    rst_i = 1'b0;

    for (int i = 0; i < 12; i++) begin
      rd_chk($sformatf("default@%03h", def_addr[i][11:0]), def_addr[i], def_val[i]);
    end

    // Prescaler 3: 42 enabled edges give one tick per 4 edges -> 10.
    wr(32'h004, 32'd3);
    wr(32'h000, 32'd1);
    repeat (40) @(negedge clk_i);
    wr(32'h000, 32'd0);
    rd_chk("presc3.mtime_lo", 32'h008, 32'd10);
    rd_chk("presc3.mtime_hi", 32'h00C, 32'd0);
    // Prescaler 0: 22 enabled edges -> +22.
    wr(32'h004, 32'd0);
    wr(32'h000, 32'd1);
    repeat (20) @(negedge clk_i);
    wr(32'h000, 32'd0);
    rd_chk("presc0.mtime_lo", 32'h008, 32'd32);

    // Channel 0 one-shot at 20; irq visible one edge after mtime reaches 20.
    wr(32'h008, 32'd0);
    wr(32'h00C, 32'd0);
    wr(32'h100, 32'd20);
    wr(32'h104, 32'd0);
    wr(32'h014, 32'd1);
    wr(32'h108, 32'd1);
    wr(32'h000, 32'd1);
    cyc = 0;
    while (!timer_irq && cyc < 100) begin
      @(negedge clk_i);
      cyc++;
    end
    check_val("oneshot.irq_cycle", 64'(cyc), 64'd21);
    wr(32'h000, 32'd0);
    rd_chk("oneshot.ch_ctrl", 32'h108, 32'd0);
    rd_chk("oneshot.status", 32'h010, 32'd1);
    check_val("oneshot.timer_irq", 64'(timer_irq), 64'd1);
    wr(32'h010, 32'd1);
    check_val("w1c.timer_irq", 64'(timer_irq), 64'd0);
    rd_chk("w1c.status", 32'h010, 32'd0);

    // Channel 1 periodic CMP=10 PERIOD=5, stepped one tick at a time.
    wr(32'h008, 32'd0);
    wr(32'h00C, 32'd0);
    wr(32'h110, 32'd10);
    wr(32'h114, 32'd0);
    wr(32'h11C, 32'd5);
    wr(32'h014, 32'd2);
    wr(32'h118, 32'd3);
    for (int m = 1; m <= 20; m++) begin
      tick_once();
      exp_irq = (m == 10) || (m == 15) || (m == 20);
      check_val($sformatf("periodic.irq1@mtime%0d", m), 64'(irq_vec[1]), 64'(exp_irq));
      if (exp_irq) wr(32'h010, 32'd2);
    end
    rd_chk("periodic.cmp_lo", 32'h110, 32'd25);
    rd_chk("periodic.cmp_hi", 32'h114, 32'd0);

    // 64-bit wrap and shadowed high-word reads.
    wr(32'h118, 32'd0);
    wr(32'h008, 32'hFFFF_FFFE);
    wr(32'h00C, 32'hFFFF_FFFF);
    repeat (3) tick_once();
    rd_chk("wrap.mtime_lo", 32'h008, 32'd1);
    rd_chk("wrap.mtime_hi", 32'h00C, 32'd0);
    rd_chk("shadow.lo", 32'h008, 32'd1);
    wr(32'h00C, 32'h1234_5678);
    rd_chk("shadow.hi_stale", 32'h00C, 32'd0);
    rd_chk("shadow.lo2", 32'h008, 32'd1);
    rd_chk("shadow.hi_new", 32'h00C, 32'h1234_5678);

    // Bus errors: channel 4 does not exist, 0x018 is unmapped.
    bus_xfer(1'b0, 32'h140, 32'd0, 4'hF, rd, er);
    check_val("err140.rd.err", 64'(er), 64'd1);
    check_val("err140.rd.rdata", 64'(rd), 64'd0);
    bus_xfer(1'b1, 32'h140, 32'h0000_DEAD, 4'hF, rd, er);
    check_val("err140.wr.err", 64'(er), 64'd1);
    rd_chk("err140.ch0_cmp_kept", 32'h100, 32'd20);
    bus_xfer(1'b1, 32'h018, 32'hFFFF_FFFF, 4'hF, rd, er);
    check_val("err018.wr.err", 64'(er), 64'd1);
    bus_xfer(1'b0, 32'h018, 32'd0, 4'hF, rd, er);
    check_val("err018.rd.err", 64'(er), 64'd1);
    rd_chk("err018.irq_en_kept", 32'h014, 32'd2);
    rd_chk("err018.status_kept", 32'h010, 32'd0);

    // Byte enables.
    wr(32'h10C, 32'hAABB_CCDD);
    wr(32'h10C, 32'h1122_3344, 4'b0101);
    rd_chk("be.period0", 32'h10C, 32'hAA22_CC44);

    // New match beats a same-cycle W1C of that status bit.
    wr(32'h008, 32'd0);
    wr(32'h00C, 32'd0);
    wr(32'h100, 32'd5);
    wr(32'h104, 32'd0);
    wr(32'h108, 32'd1);
    wr_pair(32'h008, 32'd5, 32'h010, 32'd1);
    rd_chk("coll.w1c_vs_match", 32'h010, 32'd1);
    rd_chk("coll.oneshot_cleared", 32'h108, 32'd0);

    // CH_CTRL write beats one-shot auto-clear; the next match then reloads.
    wr(32'h010, 32'd1);
    wr_pair(32'h108, 32'd1, 32'h108, 32'd3);
    rd_chk("coll.chctrl_vs_clear", 32'h108, 32'd3);
    rd_chk("coll.reload_cmp_lo", 32'h100, 32'hAA22_CC49);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
